// File: rtl/step_motor_ctrl.sv
// Stepper motor phase sequencer: runs a requested number of steps at a programmable rate.
// Define STEP_HALF_EN for the 8-entry half-step table; the default build uses the 4-entry full-step table.
module step_motor_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dir,
  input  logic [7:0] steps,
  input  logic [7:0] period,
  input  logic       abort,
  output logic [3:0] phase,
  output logic       busy,
  output logic       done,
  output logic [7:0] remaining
);

`ifdef STEP_HALF_EN
  localparam int IDX_W = 3;

  function automatic logic [3:0] pattern(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    pattern = 4'b1000;
      3'd1:    pattern = 4'b1100;
      3'd2:    pattern = 4'b0100;
      3'd3:    pattern = 4'b0110;
      3'd4:    pattern = 4'b0010;
      3'd5:    pattern = 4'b0011;
      3'd6:    pattern = 4'b0001;
      default: pattern = 4'b1001;
    endcase
  endfunction
`else
  localparam int IDX_W = 2;

  function automatic logic [3:0] pattern(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    pattern = 4'b1000;
      2'd1:    pattern = 4'b0100;
      2'd2:    pattern = 4'b0010;
      default: pattern = 4'b0001;
    endcase
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       presc_q, presc_d;
  logic [7:0]       rem_q, rem_d;
  logic [7:0]       period_q, period_d;
  logic             dir_q, dir_d;
  logic [3:0]       phase_q;
  logic             busy_q, done_q;

  // NOTE: every _d gets a default first so no path through the case leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    presc_d  = presc_q;
    rem_d    = rem_q;
    period_d = period_q;
    dir_d    = dir_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dir_d    = dir;
          period_d = period;
          rem_d    = steps;
          presc_d  = 8'd0;
          state_d  = (steps == 8'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (presc_q == period_q) begin
          presc_d = 8'd0;
          idx_d   = dir_q ? idx_q + 1'b1 : idx_q - 1'b1;
          rem_d   = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = DONE;
        end else begin
          presc_d = presc_q + 8'd1;
        end
        // A step due on the abort cycle has already been applied above.
        if (abort) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      presc_q  <= 8'd0;
      rem_q    <= 8'd0;
      period_q <= 8'd0;
      dir_q    <= 1'b0;
      phase_q  <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      presc_q  <= presc_d;
      rem_q    <= rem_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      // Outputs are registered from the next state so they line up with state_q.
      phase_q  <= (state_d == IDLE) ? 4'b0000 : pattern(idx_d);
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  assign phase     = phase_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_step_motor_ctrl.sv
// Randomised and directed bench for step_motor_ctrl; expected outputs come from arithmetic on the move parameters.
// Honours STEP_HALF_EN the same way as the design.
module tb_step_motor_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, dir, abort;
  logic [7:0] steps, period;
  logic [3:0] phase;
  logic       busy, done;
  logic [7:0] remaining;

  int checks = 0;
  int errors = 0;
  int model_idx = 0;

`ifdef STEP_HALF_EN
  localparam int N = 8;
`else
  localparam int N = 4;
`endif

  step_motor_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir       (dir),
    .steps     (steps),
    .period    (period),
    .abort     (abort),
    .phase     (phase),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pat(input int i);
    int k;
    k = ((i % N) + N) % N;
`ifdef STEP_HALF_EN
    case (k)
      0: return 4'b1000;
      1: return 4'b1100;
      2: return 4'b0100;
      3: return 4'b0110;
      4: return 4'b0010;
      5: return 4'b0011;
      6: return 4'b0001;
      default: return 4'b1001;
    endcase
`else
    case (k)
      0: return 4'b1000;
      1: return 4'b0100;
      2: return 4'b0010;
      default: return 4'b0001;
    endcase
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] ph, input logic b,
                            input logic d, input logic [7:0] r);
    check({tag, ".phase"}, {4'b0, phase}, {4'b0, ph});
    check({tag, ".busy"}, {7'b0, busy}, {7'b0, b});
    check({tag, ".done"}, {7'b0, done}, {7'b0, d});
    check({tag, ".remaining"}, remaining, r);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("reset", 4'b0000, 1'b0, 1'b0, 8'd0);
    model_idx = 0;
  endtask

  // One move: steps advance every p+1 clocks; abort_at / rst_at are RUN-cycle offsets (-1 = never).
  task automatic do_move(input logic d, input int n, input int p, input int abort_at, input int rst_at);
    int sgn, idx0, run_len, done_steps, s;
    sgn  = d ? 1 : -1;
    idx0 = model_idx;
    if (n == 0) begin
      run_len    = 0;
      done_steps = 0;
    end else if (abort_at >= 0) begin
      run_len    = abort_at + 1;
      done_steps = (abort_at + 1) / (p + 1);
    end else begin
      run_len    = n * (p + 1);
      done_steps = n;
    end
    start  = 1'b1;
    dir    = d;
    steps  = 8'(n);
    period = 8'(p);
    tick();
    start  = 1'b0;
    dir    = 1'($urandom);
    steps  = 8'($urandom);
    period = 8'($urandom);
    for (int c = 0; c < run_len; c++) begin
      s = c / (p + 1);
      expect_out("run", pat(idx0 + sgn * s), 1'b1, 1'b0, 8'(n - s));
      if (c == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("rst_mid", 4'b0000, 1'b0, 1'b0, 8'd0);
        tick();
        expect_out("post_rst", 4'b0000, 1'b0, 1'b0, 8'd0);
        model_idx = 0;
        return;
      end
      abort = (c == abort_at);
      start = ($urandom_range(0, 3) == 0);
      tick();
      abort = 1'b0;
      start = 1'b0;
    end
    expect_out("done", pat(idx0 + sgn * done_steps), 1'b0, 1'b1, 8'(n - done_steps));
    start = 1'($urandom);
    abort = 1'($urandom);
    tick();
    start = 1'b0;
    abort = 1'b0;
    expect_out("idle", 4'b0000, 1'b0, 1'b0, 8'(n - done_steps));
    model_idx = ((idx0 + sgn * done_steps) % N + N) % N;
  endtask

  initial begin
    int n, p, a;
    logic d;
    rst    = 1'b1;
    start  = 1'b0;
    dir    = 1'b0;
    abort  = 1'b0;
    steps  = 8'd0;
    period = 8'd0;
    tick();
    reset_dut();
    tick();
    expect_out("idle_after_reset", 4'b0000, 1'b0, 1'b0, 8'd0);

    do_move(1'b1, 3, 0, -1, -1);
    reset_dut();
    do_move(1'b0, 2, 3, -1, -1);
    do_move(1'b1, 0, 2, -1, -1);
    do_move(1'b1, 200, 1, 19, -1);
    do_move(1'b0, 5, 0, -1, -1);
    do_move(1'b1, 50, 2, -1, 37);
    do_move(1'b1, 9, 0, -1, -1);

    for (int i = 0; i < 25; i++) begin
      d = 1'($urandom);
      n = $urandom_range(0, 40);
      p = $urandom_range(0, 4);
      a = -1;
      if (n > 0 && $urandom_range(0, 2) == 0) a = $urandom_range(0, n * (p + 1) - 1);
      do_move(d, n, p, a, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_motor_ctrl.md
STEP_MOTOR_CTRL -- requirements
Module: step_motor_ctrl

Interface
REQ-001 The block SHALL have port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-002 The block SHALL have port: rst  input  1  synchronous, active-high reset; sampled on the clk rising edge only.
REQ-003 The block SHALL have port: start  input  1  request a move; sampled only in IDLE.
REQ-004 The block SHALL have port: dir  input  1  1 = forward rotation, 0 = reverse; latched with start.
REQ-005 The block SHALL have port: steps  input  8  number of phase advances requested; latched with start.
REQ-006 The block SHALL have port: period  input  8  clocks per step minus one; latched with start.
REQ-007 The block SHALL have port: abort  input  1  terminate a move in progress; ignored outside RUN.
REQ-008 The block SHALL have port: phase  output  4  coil drive pattern, bit 3 = coil A.
REQ-009 The block SHALL have port: busy  output  1  high in RUN.
REQ-010 The block SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port: remaining  output  8  steps still to execute in the current move.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 In IDLE, start=1 with steps!=0 SHALL latch dir, steps and period, clear the prescaler and enter RUN on the next cycle.
REQ-014 In IDLE, start=1 with steps==0 SHALL enter DONE directly, with no phase advance.
REQ-015 In RUN, the 8-bit prescaler SHALL count 0..period, i.e. period+1 clocks per step; period=0 gives one step per clock.
REQ-016 On the cycle the prescaler equals period, the phase index SHALL advance: +1 if dir=1, -1 if dir=0, modulo sequence length. On the same cycle remaining SHALL decrement and the prescaler SHALL return to 0.
REQ-017 The full-step sequence SHALL be 1000, 0100, 0010, 0001, with index 0 = 1000 and wrap 0001->1000 (forward) or 1000->0001 (reverse).
REQ-018 When remaining decrements from 1 to 0, the FSM SHALL enter DONE on the next cycle.
REQ-019 abort=1 in RUN SHALL enter DONE on the next cycle; any step due that same cycle SHALL still execute; the phase index SHALL be retained.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 start asserted in RUN or DONE SHALL be ignored and not queued.
REQ-022 phase SHALL show the pattern at the current index in RUN and DONE, and SHALL be 0000 in IDLE (coils de-energised). The index SHALL persist across moves.
REQ-023 busy SHALL equal (state==RUN); remaining SHALL hold its final value until the next accepted start.

Reset
REQ-024 rst=1 SHALL force, on the next clk edge and regardless of state: state=IDLE, index=0, prescaler=0, remaining=0, busy=0, done=0, phase=0000.
REQ-025 rst SHALL take priority over start and abort; a reset mid-move SHALL abandon the move with no done pulse.

Configuration
REQ-026 With STEP_HALF_EN defined, the sequence SHALL be the 8-entry half-step table 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001 with a 3-bit index wrapping modulo 8, and each step SHALL advance one entry.
REQ-027 Without STEP_HALF_EN, the block SHALL implement only the 4-entry full-step table of REQ-017, with a 2-bit index.

Verification
REQ-028 Reset, then start, dir=1, steps=3, period=0 -> phase 1000, 0100, 0010, 0001 on consecutive RUN/DONE cycles; done pulses once; then phase=0000.
REQ-029 Start, dir=0, steps=2, period=3 from index 0 -> phase 1000 for 4 clocks, 0001 for 4 clocks, then 0010; done one cycle after the second step.
REQ-030 steps=0 with start -> done=1 exactly one cycle later, busy never high, index unchanged.
REQ-031 steps=200, period=1, abort after 10 steps -> done next cycle, remaining=190, a following start resumes from the retained index.
REQ-032 rst asserted mid-move (steps=50) -> all outputs zero next cycle, no done pulse; start asserted while busy -> no effect on remaining.
REQ-033 With STEP_HALF_EN, dir=1, steps=9, period=0 -> phase walks the 8-entry table and wraps to 1100 on the ninth step.
